// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the LEGv8-style execute stage:
//   - alu_op_e    : 4-bit ALU operation codes produced by the ALU-control
//                   decoder and consumed by the ALU datapath.
//   - RTYPE_*     : 11-bit R-type opcode patterns (instruction[31:21]).
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_ORR     = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_PASS_B  = 4'b0111,
    ALU_NOR     = 4'b1100,
    ALU_INVALID = 4'b1111
  } alu_op_e;

  localparam logic [10:0] RTYPE_ADD = 11'b100_0101_1000;
  localparam logic [10:0] RTYPE_SUB = 11'b110_0101_1000;
  localparam logic [10:0] RTYPE_AND = 11'b100_0101_0000;
  localparam logic [10:0] RTYPE_ORR = 11'b101_0101_0000;

endpackage

// File: rtl/alu_control_decode.sv
// -----------------------------------------------------------------------------
// alu_control_decode
// Purely combinational ALU-control decoder: maps the control-unit ALUOp bits
// and the instruction opcode field to a 4-bit ALU operation code.
// Ports:
//   i_aluop1, i_aluop0 : ALUOp control bits
//   i_instr_part       : instruction[31:21]
//   o_op_code          : decoded ALU operation code
// -----------------------------------------------------------------------------
module alu_control_decode
  import alu_pkg::*;
(
  input  logic        i_aluop1,
  input  logic        i_aluop0,
  input  logic [10:0] i_instr_part,
  output alu_op_e     o_op_code
);

  always_comb begin
    o_op_code = ALU_INVALID;
    // ALUOp0 (CBZ) wins over ALUOp1, so ALUOp=11 still passes B.
    if (i_aluop0) begin
      o_op_code = ALU_PASS_B;
    end else if (!i_aluop1) begin
      o_op_code = ALU_ADD;
    end else begin
      case (i_instr_part)
        RTYPE_ADD: o_op_code = ALU_ADD;
        RTYPE_SUB: o_op_code = ALU_SUB;
        RTYPE_AND: o_op_code = ALU_AND;
        RTYPE_ORR: o_op_code = ALU_ORR;
        default:   o_op_code = ALU_INVALID;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Registered execute stage: ALU-control decode, WIDTH-bit ALU with zero flag,
// and an independent WIDTH-bit adder (PC+4 / branch target). All outputs are
// registered, giving one cycle of latency and one operation per cycle.
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   in_valid              : inputs valid qualifier
//   ALUOp1, ALUOp0        : ALUOp control bits
//   instruction_part      : instruction[31:21]
//   input_data_1/2        : ALU operands A / B
//   adder_data_1/2        : adder operands
//   out_valid             : in_valid delayed one cycle
//   operation_code        : registered ALU operation code
//   output_data           : registered ALU result
//   output_zero           : registered "result is zero" flag
//   adder_output          : registered adder sum
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             ALUOp1,
  input  logic             ALUOp0,
  input  logic [10:0]      instruction_part,
  input  logic [WIDTH-1:0] input_data_1,
  input  logic [WIDTH-1:0] input_data_2,
  input  logic [WIDTH-1:0] adder_data_1,
  input  logic [WIDTH-1:0] adder_data_2,
  output logic             out_valid,
  output logic [3:0]       operation_code,
  output logic [WIDTH-1:0] output_data,
  output logic             output_zero,
  output logic [WIDTH-1:0] adder_output
);

  alu_op_e          w_op_code;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;
  logic [WIDTH-1:0] w_adder_sum;

  logic             r_vld_p0;
  logic [3:0]       r_op_code_p0;
  logic [WIDTH-1:0] r_result_p0;
  logic             r_zero_p0;
  logic [WIDTH-1:0] r_adder_p0;

  alu_control_decode u_decode (
    .i_aluop1     (ALUOp1),
    .i_aluop0     (ALUOp0),
    .i_instr_part (instruction_part),
    .o_op_code    (w_op_code)
  );

  // Add/subtract wrap modulo 2^WIDTH; unsupported codes yield zero.
  always_comb begin
    w_alu_result = '0;
    case (w_op_code)
      ALU_AND:    w_alu_result = input_data_1 & input_data_2;
      ALU_ORR:    w_alu_result = input_data_1 | input_data_2;
      ALU_ADD:    w_alu_result = input_data_1 + input_data_2;
      ALU_SUB:    w_alu_result = input_data_1 - input_data_2;
      ALU_PASS_B: w_alu_result = input_data_2;
      ALU_NOR:    w_alu_result = ~(input_data_1 | input_data_2);
      default:    w_alu_result = '0;
    endcase
  end

  assign w_alu_zero  = (w_alu_result == '0);
  assign w_adder_sum = adder_data_1 + adder_data_2;

  // ---- stage boundary: output registers (load every cycle) ----
  // Reset zero flag is 1 so it stays consistent with the cleared result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p0     <= 1'b0;
      r_op_code_p0 <= 4'b0000;
      r_result_p0  <= '0;
      r_zero_p0    <= 1'b1;
      r_adder_p0   <= '0;
    end else begin
      r_vld_p0     <= in_valid;
      r_op_code_p0 <= w_op_code;
      r_result_p0  <= w_alu_result;
      r_zero_p0    <= w_alu_zero;
      r_adder_p0   <= w_adder_sum;
    end
  end

  assign out_valid      = r_vld_p0;
  assign operation_code = r_op_code_p0;
  assign output_data    = r_result_p0;
  assign output_zero    = r_zero_p0;
  assign adder_output   = r_adder_p0;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        ALUOp1;
  logic        ALUOp0;
  logic [10:0] instruction_part;
  logic [63:0] input_data_1;
  logic [63:0] input_data_2;
  logic [63:0] adder_data_1;
  logic [63:0] adder_data_2;
  logic        out_valid;
  logic [3:0]  operation_code;
  logic [63:0] output_data;
  logic        output_zero;
  logic [63:0] adder_output;

  int n_total;
  int n_pass;

  alu_exec_unit #(.WIDTH(64)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .ALUOp1           (ALUOp1),
    .ALUOp0           (ALUOp0),
    .instruction_part (instruction_part),
    .input_data_1     (input_data_1),
    .input_data_2     (input_data_2),
    .adder_data_1     (adder_data_1),
    .adder_data_2     (adder_data_2),
    .out_valid        (out_valid),
    .operation_code   (operation_code),
    .output_data      (output_data),
    .output_zero      (output_zero),
    .adder_output     (adder_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        op1;
    logic        op0;
    logic [10:0] instr;
    logic        vld;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [3:0]  code;
    logic [63:0] res;
    logic        zero;
    logic [63:0] sum;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_code"},  64'(operation_code), 64'd0);
    check({tag, "_data"},  output_data, 64'd0);
    check({tag, "_zero"},  64'(output_zero), 64'd1);
    check({tag, "_adder"}, adder_output, 64'd0);
  endtask

  task automatic drive_random();
    in_valid         = 1'b1;
    ALUOp1           = 1'b1;
    ALUOp0           = 1'b0;
    instruction_part = 11'h458;
    input_data_1     = {$urandom, $urandom} | 64'h1;
    input_data_2     = {$urandom, $urandom};
    adder_data_1     = {$urandom, $urandom} | 64'h1;
    adder_data_2     = 64'd0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{1'b1, 1'b0, 11'h458, 1'b1, 64'hF0, 64'h3C, 64'h1000, 64'h4,
                 4'b0010, 64'h12C, 1'b0, 64'h1004};
    vecs[1]  = '{1'b1, 1'b0, 11'h658, 1'b0, 64'hF0, 64'h3C, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0,
                 4'b0110, 64'hB4, 1'b0, 64'hFF0};
    vecs[2]  = '{1'b1, 1'b0, 11'h450, 1'b1, 64'hF0, 64'h3C, 64'h2000, 64'h10,
                 4'b0000, 64'h30, 1'b0, 64'h2010};
    vecs[3]  = '{1'b1, 1'b0, 11'h550, 1'b0, 64'hF0, 64'h3C, 64'h0, 64'h0,
                 4'b0001, 64'hFC, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 1'b0, 11'h7FF, 1'b1, 64'hF0, 64'h3C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                 4'b1111, 64'h0, 1'b1, 64'h0};
    vecs[5]  = '{1'b0, 1'b0, 11'h7FF, 1'b0, 64'h100, 64'h8, 64'h8, 64'h8,
                 4'b0010, 64'h108, 1'b0, 64'h10};
    vecs[6]  = '{1'b0, 1'b1, 11'h458, 1'b1, 64'h55, 64'h0, 64'h7, 64'h9,
                 4'b0111, 64'h0, 1'b1, 64'h10};
    vecs[7]  = '{1'b1, 1'b1, 11'h658, 1'b0, 64'h55, 64'h0, 64'h123, 64'h1,
                 4'b0111, 64'h0, 1'b1, 64'h124};
    vecs[8]  = '{1'b0, 1'b1, 11'h000, 1'b1, 64'h55, 64'h5, 64'h400, 64'h400,
                 4'b0111, 64'h5, 1'b0, 64'h800};
    vecs[9]  = '{1'b1, 1'b0, 11'h458, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h1,
                 4'b0010, 64'h0, 1'b1, 64'h1};
    vecs[10] = '{1'b1, 1'b0, 11'h658, 1'b1, 64'h0, 64'h1, 64'h10, 64'h20,
                 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h30};
    vecs[11] = '{1'b0, 1'b0, 11'h000, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h5, 64'h5, 4'b0010, 64'h0, 1'b1, 64'hA};

    // Reset held low with random inputs while clocking.
    reset_n = 1'b0;
    drive_random();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("rst_hold");

    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back table vectors; in_valid alternates each cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      ALUOp1           = vecs[i].op1;
      ALUOp0           = vecs[i].op0;
      instruction_part = vecs[i].instr;
      in_valid         = vecs[i].vld;
      input_data_1     = vecs[i].a;
      input_data_2     = vecs[i].b;
      adder_data_1     = vecs[i].d1;
      adder_data_2     = vecs[i].d2;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_code", i),  64'(operation_code), 64'(vecs[i].code));
      check($sformatf("v%0d_data", i),  output_data, vecs[i].res);
      check($sformatf("v%0d_zero", i),  64'(output_zero), 64'(vecs[i].zero));
      check($sformatf("v%0d_adder", i), adder_output, vecs[i].sum);
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].vld));
    end

    // Hand sequence: adder stream with in_valid toggling, out_valid one cycle behind.
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      in_valid     = (k % 2 == 0);
      adder_data_1 = 64'h1000;
      adder_data_2 = 64'(4 * k);
      @(posedge clock);
      #1;
      check($sformatf("seq%0d_valid", k), 64'(out_valid), 64'((k % 2) == 0));
      check($sformatf("seq%0d_adder", k), adder_output, 64'h1000 + 64'(4 * k));
    end

    // Mid-stream async reset: outputs must clear with no clock edge.
    @(negedge clock);
    drive_random();
    @(posedge clock);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_data_nz", 64'(output_data != 64'd0), 64'd1);
    @(negedge clock);
    drive_random();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(posedge clock);
    #1;
    check_reset_values("rst_async_hold");

    // First capture after release happens on the next rising edge.
    @(negedge clock);
    reset_n          = 1'b1;
    in_valid         = 1'b1;
    ALUOp1           = 1'b0;
    ALUOp0           = 1'b0;
    input_data_1     = 64'h100;
    input_data_2     = 64'h8;
    adder_data_1     = 64'h1000;
    adder_data_2     = 64'h4;
    @(posedge clock);
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data",  output_data, 64'h108);
    check("post_rst_adder", adder_output, 64'h1004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
